// File: rtl/ula_muldiv.sv
// ula_muldiv: execute-stage ALU with an iterative MULT/DIV engine.
//   Single-cycle ops: AND, OR, ADD, SUB, SLL, SRL, SRA, SLT, NOR, XOR, LUI.
//   MULT/DIV run as a shift-add / restoring-divide over WIDTH cycles,
//   with signed and unsigned modes, and leave results in internal HI/LO.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   op_valid       : opcode/operands valid this cycle
//   Unsigned       : unsigned MULT/DIV/SLT, suppresses O
//   ULAopcode      : operation select
//   A, B, shamt    : operands and shift amount
//   R, Z, O        : result, zero flag, signed overflow (combinational)
//   busy, done     : engine running / one-cycle completion pulse (registered)
//   stall          : current op cannot complete this cycle (combinational)
module ula_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             Unsigned,
  input  logic [3:0]       ULAopcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             O,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = SHW + 1;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_SRA  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MULT = 4'b1000,
    OP_DIV  = 4'b1001,
    OP_MFLO = 4'b1010,
    OP_MFHI = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_XOR  = 4'b1101,
    OP_LUI  = 4'b1110,
    OP_ZERO = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  // Engine working registers: wh/wl form the shifting {HI,LO} pair,
  // mcand holds the multiplicand or divisor magnitude.
  logic [WIDTH-1:0] wh, wl, mcand, a_orig;
  logic             is_div, neg_q, neg_r, dz;

  logic             is_md, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_tr;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH-1:0] sum, diff, r_int;
  logic             slt;

  // ---------------------------------------------------------------------
  // Engine datapath
  // ---------------------------------------------------------------------
  always_comb begin
    is_md  = (ULAopcode == OP_MULT) || (ULAopcode == OP_DIV);
    accept = op_valid && is_md && (state == IDLE);
    mag_a  = (!Unsigned && A[WIDTH-1]) ? -A : A;
    mag_b  = (!Unsigned && B[WIDTH-1]) ? -B : B;

    // Multiply step: add multiplicand when LSB of multiplier set, shift right.
    mul_sum = {1'b0, wh} + (wl[0] ? {1'b0, mcand} : '0);
    // Divide step: shift in next dividend bit, trial-subtract divisor.
    div_sh  = {wh, wl[WIDTH-1]};
    div_tr  = div_sh - {1'b0, mcand};

    prod     = {wh, wl};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -wl : wl;
    r_fix    = neg_r ? -wh : wh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wh     <= '0;
      wl     <= '0;
      mcand  <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= (ULAopcode == OP_DIV);
            // Product and quotient share the same sign rule.
            neg_q  <= !Unsigned && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= !Unsigned && A[WIDTH-1];
            dz     <= (B == '0);
            a_orig <= A;
            wh     <= '0;
            if (ULAopcode == OP_DIV) begin
              wl    <= mag_a;
              mcand <= mag_b;
            end else begin
              wl    <= mag_b;
              mcand <= mag_a;
            end
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            if (!div_tr[WIDTH]) begin
              wh <= div_tr[WIDTH-1:0];
              wl <= {wl[WIDTH-2:0], 1'b1};
            end else begin
              wh <= div_sh[WIDTH-1:0];
              wl <= {wl[WIDTH-2:0], 1'b0};
            end
          end else begin
            wh <= mul_sum[WIDTH:1];
            wl <= {mul_sum[0], wl[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (dz) begin
              lo <= '1;
              hi <= a_orig;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------
  always_comb begin
    sum   = A + B;
    diff  = A - B;
    slt   = Unsigned ? (A < B) : ($signed(A) < $signed(B));
    r_int = '0;
    O     = 1'b0;
    case (ULAopcode)
      OP_AND:  r_int = A & B;
      OP_OR:   r_int = A | B;
      OP_ADD: begin
        r_int = sum;
        O     = !Unsigned && (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  r_int = B << shamt;
      OP_SRL:  r_int = B >> shamt;
      OP_SRA:  r_int = $signed(B) >>> shamt;
      OP_SUB: begin
        r_int = diff;
        O     = !Unsigned && (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  r_int = {{(WIDTH-1){1'b0}}, slt};
      OP_MFLO: r_int = lo;
      OP_MFHI: r_int = hi;
      OP_NOR:  r_int = ~(A | B);
      OP_XOR:  r_int = A ^ B;
      OP_LUI:  r_int = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: r_int = '0;
    endcase
    R     = r_int;
    Z     = (r_int == '0);
    stall = op_valid && busy &&
            (is_md || (ULAopcode == OP_MFLO) || (ULAopcode == OP_MFHI));
  end

endmodule

// File: tb/tb_ula_muldiv.sv
module tb_ula_muldiv;

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_SLL  = 4'b0011, OP_SRL  = 4'b0100, OP_SRA  = 4'b0101,
                         OP_SUB  = 4'b0110, OP_SLT  = 4'b0111, OP_MULT = 4'b1000,
                         OP_DIV  = 4'b1001, OP_MFLO = 4'b1010, OP_MFHI = 4'b1011,
                         OP_NOR  = 4'b1100, OP_XOR  = 4'b1101, OP_LUI  = 4'b1110,
                         OP_ZERO = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        Unsigned;
  logic [3:0]  ULAopcode;
  logic [31:0] A, B;
  logic [4:0]  shamt;
  logic [31:0] R;
  logic        Z, O, busy, done, stall;

  int tests  = 0;
  int failed = 0;

  ula_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .Unsigned(Unsigned),
    .ULAopcode(ULAopcode), .A(A), .B(B), .shamt(shamt),
    .R(R), .Z(Z), .O(O), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic u, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    op_valid  = v;
    Unsigned  = u;
    ULAopcode = op;
    A         = a;
    B         = b;
    shamt     = sh;
  endtask

  // Combinational ALU check: R, Z, O.
  task automatic alu(input string tag, input logic u, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                     input logic [31:0] er, input logic ez, input logic eo);
    set_op(1'b1, u, op, a, b, sh);
    #1;
    check({tag, "_R"}, R, er);
    check({tag, "_Z"}, {31'b0, Z}, {31'b0, ez});
    check({tag, "_O"}, {31'b0, O}, {31'b0, eo});
  endtask

  // Issue MULT/DIV, count busy cycles, then read LO/HI in the done cycle.
  task automatic run_md(input string tag, input logic u, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    set_op(1'b1, u, op, a, b, 5'd0);
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_busycyc"}, n, 33);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    set_op(1'b1, 1'b0, OP_MFLO, 32'h0, 32'h0, 5'd0);
    #1;
    check({tag, "_LO"}, R, exp_lo);
    check({tag, "_stall"}, {31'b0, stall}, 32'd0);
    set_op(1'b1, 1'b0, OP_MFHI, 32'h0, 32'h0, 5'd0);
    #1;
    check({tag, "_HI"}, R, exp_hi);
    set_op(1'b0, 1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    check({tag, "_donepulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    set_op(1'b0, 1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    set_op(1'b1, 1'b0, OP_MFLO, 32'h0, 32'h0, 5'd0);
    #1;
    check("rst_LO", R, 32'h0);
    check("rst_Z", {31'b0, Z}, 32'd1);

    // Single-cycle ALU vectors
    alu("add_ovf_s",  1'b0, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1);
    alu("add_ovf_u",  1'b1, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b0);
    alu("sub_ovf",    1'b0, OP_SUB, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1);
    alu("sub_zero",   1'b0, OP_SUB, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0);
    alu("and",        1'b0, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0);
    alu("or",         1'b0, OP_OR,  32'hF0F0F0F0, 32'h0F000000, 5'd0, 32'hFFF0F0F0, 1'b0, 1'b0);
    alu("xor",        1'b0, OP_XOR, 32'hFFFF0000, 32'hF0F0F0F0, 5'd0, 32'h0F0FF0F0, 1'b0, 1'b0);
    alu("nor",        1'b0, OP_NOR, 32'hFFFF0000, 32'h0000FFF0, 5'd0, 32'h0000000F, 1'b0, 1'b0);
    alu("sll",        1'b0, OP_SLL, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0);
    alu("srl",        1'b0, OP_SRL, 32'h0, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0);
    alu("sra",        1'b0, OP_SRA, 32'h0, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0);
    alu("slt_s",      1'b0, OP_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h1, 1'b0, 1'b0);
    alu("slt_u",      1'b1, OP_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h0, 1'b1, 1'b0);
    alu("slt_s_ovf",  1'b0, OP_SLT, 32'h80000000, 32'h00000001, 5'd0, 32'h1, 1'b0, 1'b0);
    alu("lui",        1'b0, OP_LUI, 32'h0, 32'h1234ABCD, 5'd0, 32'hABCD0000, 1'b0, 1'b0);
    alu("op_f",       1'b0, OP_ZERO, 32'h12345678, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0);

    // MULT/DIV engine
    run_md("mul_s",    1'b0, OP_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_md("mul_u",    1'b1, OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("div_u",    1'b1, OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14);
    run_md("div_s",    1'b0, OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_min",  1'b0, OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_md("div0_s",   1'b0, OP_DIV,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF);
    run_md("div0_u",   1'b1, OP_DIV,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF);

    // Stall behaviour: MULT 6*7, then ADD, ignored MULT, and held MFLO.
    @(negedge clk);
    set_op(1'b1, 1'b0, OP_MULT, 32'd6, 32'd7, 5'd0);
    @(posedge clk); #1;                     // E0
    set_op(1'b0, 1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
    repeat (5) @(posedge clk);              // E5
    #1;
    set_op(1'b1, 1'b0, OP_ADD, 32'd2, 32'd3, 5'd0);
    #1;
    check("busy_add_stall", {31'b0, stall}, 32'd0);
    check("busy_add_R", R, 32'd5);
    set_op(1'b1, 1'b0, OP_MULT, 32'd2, 32'd2, 5'd0);
    #1;
    check("busy_mult_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;                     // E6: second MULT must be ignored
    set_op(1'b1, 1'b0, OP_MFLO, 32'h0, 32'h0, 5'd0);
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("mflo_stallcyc", n, 27);
    check("mflo_done", {31'b0, done}, 32'd1);
    check("mflo_R", R, 32'd42);
    set_op(1'b1, 1'b0, OP_MFHI, 32'h0, 32'h0, 5'd0);
    #1;
    check("mfhi_R", R, 32'd0);
    set_op(1'b0, 1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_mult_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    set_op(1'b1, 1'b1, OP_DIV, 32'd100, 32'd7, 5'd0);
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
    repeat (10) @(posedge clk);
    #3;
    check("midrun_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    set_op(1'b1, 1'b0, OP_MFLO, 32'h0, 32'h0, 5'd0);
    #1;
    check("arst_LO", R, 32'h0);
    set_op(1'b1, 1'b0, OP_MFHI, 32'h0, 32'h0, 5'd0);
    #1;
    check("arst_HI", R, 32'h0);
    set_op(1'b0, 1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    run_md("div_post", 1'b0, OP_DIV, 32'd9, 32'd3, 32'd0, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
